mvau_inp_pingpong_buf: RTL and testbench



---
 rtl/mvau_inp_pingpong_buf.sv | 139 +++++++++++++
 tb/tb_mvau_inp_pingpong_buf.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvau_inp_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module   : mvau_inp_pingpong_buf
// Purpose  : Double-buffered input activation buffer for the MVAU datapath.
//            Accepts one vector of SF words per bank over a valid/ready
//            stream and replays it NF times (one pass per neuron fold) while
//            the other bank fills with the next vector.
// Ports    : clk          - main clock, all state on rising edge
//            rst          - synchronous active-high reset
//            in_v         - input word valid
//            in_rdy       - buffer can accept a word (write bank not full)
//            in_data      - input activation word (TI bits)
//            out_v        - output word valid
//            out_rdy      - consumer accepts output word
//            out_data     - registered output word (TI bits)
//            out_sf_last  - out_data is word SF-1 of the current pass
//            out_nf_last  - out_data is the last word of the last pass
// Revision : 1.0 - initial release
// ============================================================================
module mvau_inp_pingpong_buf #(
    parameter int SIMD  = 2,
    parameter int TSRCI = 4,
    parameter int SF    = 8,
    parameter int NF    = 4,
    localparam int TI       = SIMD * TSRCI,
    localparam int BUF_ADDR = (SF > 1) ? $clog2(SF) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_v,
    output logic          in_rdy,
    input  logic [TI-1:0] in_data,
    output logic          out_v,
    input  logic          out_rdy,
    output logic [TI-1:0] out_data,
    output logic          out_sf_last,
    output logic          out_nf_last
);

    localparam int                   c_NF_W    = (NF > 1) ? $clog2(NF) : 1;
    localparam logic [BUF_ADDR-1:0]  c_SF_LAST = BUF_ADDR'(SF - 1);
    localparam logic [c_NF_W-1:0]    c_NF_LAST = c_NF_W'(NF - 1);

    // Two banks of SF words each; contents are never reset.
    logic [TI-1:0]       r_mem [2][SF];

    logic [1:0]          r_full;
    logic                r_wb;
    logic                r_rb;
    logic [BUF_ADDR-1:0] r_wa;
    logic [BUF_ADDR-1:0] r_sf_cnt;
    logic [c_NF_W-1:0]   r_nf_cnt;

    logic                r_out_v;
    logic [TI-1:0]       r_out_data;
    logic                r_out_sf_last;
    logic                r_out_nf_last;

    logic                w_in_hs;
    logic                w_load;
    logic                w_sf_end;
    logic                w_nf_end;

    assign in_rdy   = !r_full[r_wb];
    assign w_in_hs  = in_v && in_rdy;
    // The output register refills whenever it is empty or being drained.
    assign w_load   = r_full[r_rb] && (!r_out_v || out_rdy);
    assign w_sf_end = (r_sf_cnt == c_SF_LAST);
    assign w_nf_end = (r_nf_cnt == c_NF_LAST);

    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_mem[r_wb][r_wa] <= in_data;
        end
    end

    // Writer and reader only ever touch r_full bits of different banks in the
    // same cycle (writer needs full=0, reader needs full=1), so the set and
    // the clear below never conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full   <= 2'b00;
            r_wb     <= 1'b0;
            r_rb     <= 1'b0;
            r_wa     <= '0;
            r_sf_cnt <= '0;
            r_nf_cnt <= '0;
        end else begin
            if (w_in_hs) begin
                if (r_wa == c_SF_LAST) begin
                    r_wa         <= '0;
                    r_full[r_wb] <= 1'b1;
                    r_wb         <= ~r_wb;
                end else begin
                    r_wa <= r_wa + 1'b1;
                end
            end
            if (w_load) begin
                if (w_sf_end) begin
                    r_sf_cnt <= '0;
                    if (w_nf_end) begin
                        r_nf_cnt     <= '0;
                        r_full[r_rb] <= 1'b0;
                        r_rb         <= ~r_rb;
                    end else begin
                        r_nf_cnt <= r_nf_cnt + 1'b1;
                    end
                end else begin
                    r_sf_cnt <= r_sf_cnt + 1'b1;
                end
            end
        end
    end

    // Output register: data and flags are only updated on a load, so they
    // stay frozen while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_v       <= 1'b0;
            r_out_data    <= '0;
            r_out_sf_last <= 1'b0;
            r_out_nf_last <= 1'b0;
        end else if (w_load) begin
            r_out_v       <= 1'b1;
            r_out_data    <= r_mem[r_rb][r_sf_cnt];
            r_out_sf_last <= w_sf_end;
            r_out_nf_last <= w_sf_end && w_nf_end;
        end else if (r_out_v && out_rdy) begin
            r_out_v <= 1'b0;
        end
    end

    assign out_v       = r_out_v;
    assign out_data    = r_out_data;
    assign out_sf_last = r_out_sf_last;
    assign out_nf_last = r_out_nf_last;

endmodule
`default_nettype wire

// File: tb/tb_mvau_inp_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_mvau_inp_pingpong_buf
// Purpose  : Self-checking bench for mvau_inp_pingpong_buf. Three instances
//            with different fold settings (SF/NF = 4/3, 1/4, 1/1) run the
//            same sequence of tests concurrently, each against a queue-based
//            reference model of the replay order and bank occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mvau_inp_pingpong_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    task automatic check(input int g, input string nm,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s actual=%0h required=%0h", g, nm, act, exp);
        end
    endtask

    genvar g;
    for (g = 0; g < 3; g++) begin : g_cfg
        localparam int SFV = (g == 0) ? 4 : 1;
        localparam int NFV = (g == 0) ? 3 : ((g == 1) ? 4 : 1);

        logic       rst = 1'b1;
        logic       in_v = 1'b0;
        logic       in_rdy;
        logic [7:0] in_data = 8'h00;
        logic       out_v;
        logic       out_rdy = 1'b0;
        logic [7:0] out_data;
        logic       out_sf_last;
        logic       out_nf_last;

        mvau_inp_pingpong_buf #(
            .SIMD (2),
            .TSRCI(4),
            .SF   (SFV),
            .NF   (NFV)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_v       (in_v),
            .in_rdy     (in_rdy),
            .in_data    (in_data),
            .out_v      (out_v),
            .out_rdy    (out_rdy),
            .out_data   (out_data),
            .out_sf_last(out_sf_last),
            .out_nf_last(out_nf_last)
        );

        // Reference model state: expected {data, sf_last, nf_last} stream,
        // words of the vector currently being received, and counts of whole
        // vectors stored vs. vectors whose final word has left the banks.
        logic [9:0] exp_q[$];
        logic [7:0] part[$];
        int         n_done  = 0;
        int         n_freed = 0;
        logic       prev_v = 1'b0, prev_rdy = 1'b0, prev_rst = 1'b1;
        logic [9:0] prev_word = '0;
        bit         armed = 1'b0;
        bit         stim_done = 1'b0;
        int         cnt;

        always @(negedge clk) begin
            logic [9:0] e;
            logic [9:0] a;
            logic       new_word;
            if (armed) begin
                a = {out_data, out_sf_last, out_nf_last};
                new_word = out_v && !(prev_v && !prev_rdy);
                if (prev_v && !prev_rdy && !prev_rst) begin
                    check(g, "stall_v", out_v, 1);
                    check(g, "stall_word", a, prev_word);
                end
                if (new_word && out_nf_last) n_freed++;
                // Input is blocked exactly when two whole vectors are held.
                check(g, "in_rdy", in_rdy, 32'((n_done - n_freed) < 2));
                if (rst) begin
                    exp_q.delete();
                    part.delete();
                    n_done  = 0;
                    n_freed = 0;
                end else begin
                    if (in_v && in_rdy) begin
                        part.push_back(in_data);
                        if (part.size() == SFV) begin
                            for (int nf = 0; nf < NFV; nf++)
                                for (int sf = 0; sf < SFV; sf++)
                                    exp_q.push_back({part[sf], 1'(sf == SFV - 1),
                                                     1'((sf == SFV - 1) && (nf == NFV - 1))});
                            part.delete();
                            n_done++;
                        end
                    end
                    if (out_v && out_rdy) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL cfg%0d out_unexpected actual=%0h required=none", g, a);
                        end else begin
                            e = exp_q.pop_front();
                            check(g, "out_word", a, e);
                        end
                    end
                end
            end
            prev_v    = out_v;
            prev_rdy  = out_rdy;
            prev_rst  = rst;
            prev_word = {out_data, out_sf_last, out_nf_last};
        end

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic send(input logic [7:0] d, input int gap);
            int   n;
            logic ok;
            while ($urandom_range(0, 99) < gap) tick();
            in_v    = 1'b1;
            in_data = d;
            n  = 0;
            ok = 1'b0;
            while (!ok && n < 2000) begin
                @(negedge clk);
                ok = in_rdy;
                tick();
                n++;
            end
            in_v    = 1'b0;
            in_data = 8'($urandom);
            if (!ok) check(g, "send_timeout", 0, 1);
        endtask

        task automatic drain();
            int n;
            out_rdy = 1'b1;
            n = 0;
            while ((exp_q.size() != 0 || out_v) && n < 3000) begin
                tick();
                n++;
            end
            check(g, "drain_idle", {exp_q.size() != 0, out_v}, 0);
        endtask

        initial begin
            // Reset state
            tick();
            tick();
            armed = 1'b1;
            @(negedge clk);
            check(g, "rst_out_v", out_v, 0);
            check(g, "rst_out_data", out_data, 0);
            check(g, "rst_sf_last", out_sf_last, 0);
            check(g, "rst_nf_last", out_nf_last, 0);
            tick();
            rst = 1'b0;
            @(negedge clk);
            check(g, "post_rst_in_rdy", in_rdy, 1);
            tick();

            // Single vector with latency check
            out_rdy = 1'b1;
            for (int k = 0; k < SFV; k++) send(8'(8'h11 * (k + 1)), 0);
            @(negedge clk);
            check(g, "lat_c1_out_v", out_v, 0);
            tick();
            @(negedge clk);
            check(g, "lat_c2_out_v", out_v, 1);
            check(g, "lat_c2_data", out_data, 8'h11);
            tick();
            drain();

            // Ping-pong: three back-to-back vectors, gap-free output run
            cnt = 0;
            fork
                begin
                    for (int v = 0; v < 3; v++)
                        for (int k = 0; k < SFV; k++)
                            send(8'(8'hA0 + 16 * v + k), 0);
                end
                begin
                    int n;
                    n = 0;
                    @(negedge clk);
                    while (!out_v && n < 3000) begin
                        @(negedge clk);
                        n++;
                    end
                    while (out_v && cnt < 3000) begin
                        cnt++;
                        @(negedge clk);
                    end
                end
            join
            check(g, "pp_run_len", cnt, 3 * SFV * NFV);
            tick();
            drain();

            // Random data, input gaps and output backpressure
            stim_done = 1'b0;
            fork
                begin
                    for (int v = 0; v < 10; v++)
                        for (int k = 0; k < SFV; k++)
                            send(8'($urandom), 30);
                    stim_done = 1'b1;
                end
                begin
                    while (!stim_done) begin
                        out_rdy = 1'($urandom_range(0, 1));
                        tick();
                    end
                end
            join
            drain();

            // Reset in the middle of a replay with the second bank full
            out_rdy = 1'b1;
            for (int k = 0; k < SFV; k++) send(8'(8'h50 + k), 0);
            for (int k = 0; k < SFV; k++) send(8'(8'h60 + k), 0);
            for (int k = 0; k < SFV; k++) tick();
            @(negedge clk);
            check(g, "pre_rst_busy", out_v, 1);
            tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            @(negedge clk);
            check(g, "mid_rst_out_v", out_v, 0);
            check(g, "mid_rst_in_rdy", in_rdy, 1);
            check(g, "mid_rst_nf_last", out_nf_last, 0);
            tick();
            for (int k = 0; k < SFV; k++) send(8'(8'hD0 + k), 0);
            drain();

            done_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 50000 && done_cnt < 3; i++) @(posedge clk);
        if (done_cnt < 3) begin
            checks++;
            errors++;
            $display("FAIL global_timeout actual=%0d required=3", done_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
